regfile_multiport: RTL and testbench

- Parametrised successor to the CPU integer register file.
- Supports configurable data width, register count and read-port count.
- Adds optional write-to-read bypass, an optional hardwired-zero register 0, a per-register pending scoreboard for pipelined issue, and a sequential clear engine for pipeline flush or context reset.
- Sits between decode/issue (reads, reserves) and writeback (writes) in the riscv-cpu core.

---
 rtl/regfile_multiport_if.sv | 30 +++
 rtl/regfile_multiport.sv | 96 +++++++++
 tb/tb_regfile_multiport.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// Register file bus: writeback, issue reservations, clear control and packed read ports.
interface regfile_multiport_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
);
  logic                           write_enable;
  logic [ADDR_W-1:0]              destination;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           reserve_enable;
  logic [ADDR_W-1:0]              reserve_address;
  logic                           clear_request;
  logic                           clear_busy;
  logic [NUM_READ*ADDR_W-1:0]     read_address;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_pending;

  modport master (
    output write_enable, destination, write_data, reserve_enable, reserve_address,
           clear_request, read_address,
    input  clear_busy, read_data, read_pending
  );

  modport slave (
    input  write_enable, destination, write_data, reserve_enable, reserve_address,
           clear_request, read_address,
    output clear_busy, read_data, read_pending
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with pending scoreboard, optional bypass/zero register
// and a one-register-per-cycle clear sweep.
module regfile_multiport #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1,
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
  input logic                clk,
  input logic                rst_n,
  regfile_multiport_if.slave bus
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     pend_q, pend_d;
  logic                    wr_ok, rs_ok;
  logic [ADDR_W-1:0]       ra;

  // Out-of-range (non power-of-2 depth) and the hardwired zero register are both inert.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ext;
    ext = {1'b0, a};
    return (ext < (ADDR_W+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = (state_q == StIdle) && bus.write_enable && addr_ok(bus.destination);
  assign rs_ok = (state_q == StIdle) && bus.reserve_enable && addr_ok(bus.reserve_address);
  assign bus.clear_busy = (state_q == StClear);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (wr_ok) begin
          regs_d[bus.destination] = bus.write_data;
          pend_d[bus.destination] = 1'b0;
        end
        // Reserve after write: a new producer wins over the retiring one.
        if (rs_ok) pend_d[bus.reserve_address] = 1'b1;
        if (bus.clear_request) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        regs_d[idx_q] = '0;
        pend_d[idx_q] = 1'b0;
        if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = StIdle;
        else                                idx_d   = idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    bus.read_data    = '0;
    bus.read_pending = '0;
    ra               = '0;
    for (int p = 0; p < int'(NUM_READ); p++) begin
      ra = bus.read_address[p*ADDR_W +: ADDR_W];
      if (addr_ok(ra)) begin
        bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
        bus.read_pending[p]                       = pend_q[ra];
      end
      if ((BYPASS != 0) && wr_ok && (ra == bus.destination)) begin
        bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
        bus.read_pending[p] = rs_ok && (bus.reserve_address == bus.destination);
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Drives a default build (bypass, zero reg) and a BYPASS=0/ZERO_REG=0 build in lockstep.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_multiport_if ifa ();
  regfile_multiport_if ifb ();

  regfile_multiport dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_multiport #(.BYPASS(0), .ZERO_REG(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    int          kind;  // 0 = read port, 1 = clear_busy
    int          dut;
    int          port;
    logic [31:0] data;
    logic        pend;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drive(input logic we, input logic [4:0] d, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic clr);
    ifa.write_enable = we;  ifb.write_enable = we;
    ifa.destination = d;    ifb.destination = d;
    ifa.write_data = wd;    ifb.write_data = wd;
    ifa.reserve_enable = re; ifb.reserve_enable = re;
    ifa.reserve_address = ra; ifb.reserve_address = ra;
    ifa.clear_request = clr; ifb.clear_request = clr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    ifa.read_address[p*5 +: 5] = a;
    ifb.read_address[p*5 +: 5] = a;
  endtask

  task automatic exp_rd(input int dut, input int p, input logic [31:0] d, input logic pd,
                        input string tag);
    exp_t e;
    e.kind = 0; e.dut = dut; e.port = p; e.data = d; e.pend = pd; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_both(input int p, input logic [31:0] d, input logic pd, input string tag);
    exp_rd(0, p, d, pd, tag);
    exp_rd(1, p, d, pd, tag);
  endtask

  task automatic exp_busy(input logic b, input string tag);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.kind = 1; e.dut = k; e.port = 0; e.data = 32'h0; e.pend = b; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] ad;
    logic        ap;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 1) begin
        ad = 32'h0;
        ap = (e.dut == 0) ? ifa.clear_busy : ifb.clear_busy;
      end else if (e.dut == 0) begin
        ad = ifa.read_data[e.port*32 +: 32];
        ap = ifa.read_pending[e.port];
      end else begin
        ad = ifb.read_data[e.port*32 +: 32];
        ap = ifb.read_pending[e.port];
      end
      total++;
      assert ((ad === e.data) && (ap === e.pend))
      else begin
        bad++;
        $error("FAIL %s dut%0d port%0d kind%0d: got data=%h flag=%b, want data=%h flag=%b",
               e.tag, e.dut, e.port, e.kind, ad, ap, e.data, e.pend);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #2;
    exp_both(0, 32'h0, 1'b0, "rst_held_p0");
    exp_both(1, 32'h0, 1'b0, "rst_held_p1");
    exp_busy(1'b0, "rst_held_busy");
    check();
    tick();
    rst_n = 1'b1;

    for (int r = 0; r < 32; r++) begin
      set_rd(0, 5'(r));
      set_rd(1, 5'(31 - r));
      exp_both(0, 32'h0, 1'b0, "rst_rd_p0");
      exp_both(1, 32'h0, 1'b0, "rst_rd_p1");
      exp_busy(1'b0, "rst_busy");
      #2 check();
      tick();
    end

    // Bypass: same-cycle visibility only on the bypass build
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
    set_rd(0, 5'd5);
    exp_rd(0, 0, 32'hDEAD_BEEF, 1'b0, "byp_same");
    exp_rd(1, 0, 32'h0, 1'b0, "nobyp_same");
    #2 check();
    tick();
    idle();
    exp_both(0, 32'hDEAD_BEEF, 1'b0, "wr_next");
    #2 check();

    // Zero register
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
    set_rd(0, 5'd0);
    exp_both(0, 32'h0, 1'b0, "x0_pre");
    #2 check();
    tick();
    idle();
    exp_rd(0, 0, 32'h0, 1'b0, "x0_zero");
    exp_rd(1, 0, 32'h1234, 1'b1, "x0_plain");
    #2 check();

    // Scoreboard
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    set_rd(1, 5'd7);
    tick();
    idle();
    exp_both(1, 32'h0, 1'b1, "rsv_x7");
    #2 check();
    drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0);
    exp_rd(0, 1, 32'h55, 1'b0, "wr_x7_byp");
    exp_rd(1, 1, 32'h0, 1'b1, "wr_x7_nobyp");
    #2 check();
    tick();
    idle();
    exp_both(1, 32'h55, 1'b0, "wr_x7_done");
    #2 check();
    drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 1'b0);
    set_rd(0, 5'd9);
    exp_rd(0, 0, 32'hAA, 1'b1, "rw_x9_byp");
    exp_rd(1, 0, 32'h0, 1'b0, "rw_x9_nobyp");
    #2 check();
    tick();
    idle();
    exp_both(0, 32'hAA, 1'b1, "rw_x9_done");
    #2 check();

    // Clear sweep
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    tick();
    idle();
    set_rd(0, 5'd31);
    set_rd(1, 5'd3);
    exp_both(0, 32'd31, 1'b0, "load_x31");
    exp_both(1, 32'd3, 1'b1, "load_x3");
    exp_busy(1'b0, "pre_clr_busy");
    #2 check();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 32; c++) begin
      if (c == 10) begin
        drive(1'b1, 5'd4, 32'hFFFF, 1'b1, 5'd5, 1'b0);
        set_rd(0, 5'd4);
        set_rd(1, 5'd20);
        exp_both(0, 32'h0, 1'b0, "clr_x4_nobyp");
        exp_both(1, 32'd20, 1'b0, "clr_x20_partial");
      end
      if (c == 20) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
      exp_busy(1'b1, "clr_busy");
      #2 check();
      tick();
      idle();
    end
    for (int r = 0; r < 32; r++) begin
      set_rd(0, 5'(r));
      set_rd(1, 5'(31 - r));
      exp_both(0, 32'h0, 1'b0, "post_clr_p0");
      exp_both(1, 32'h0, 1'b0, "post_clr_p1");
      exp_busy(1'b0, "post_clr_busy");
      #2 check();
      tick();
    end

    // Reset mid-sweep
    drive(1'b1, 5'd20, 32'h99, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick();
    idle();
    set_rd(0, 5'd20);
    set_rd(1, 5'd2);
    for (int c = 0; c < 10; c++) begin
      if (c == 0) exp_both(0, 32'h99, 1'b0, "mid_x20_loaded");
      exp_busy(1'b1, "mid_busy");
      #2 check();
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    exp_busy(1'b0, "mid_rst_busy");
    exp_both(0, 32'h0, 1'b0, "mid_rst_x20");
    exp_both(1, 32'h0, 1'b0, "mid_rst_x2");
    check();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 1'b0);
    set_rd(0, 5'd2);
    exp_rd(0, 0, 32'h77, 1'b0, "after_rst_byp");
    exp_rd(1, 0, 32'h0, 1'b0, "after_rst_nobyp");
    exp_busy(1'b0, "after_rst_busy");
    #2 check();
    tick();
    idle();
    exp_both(0, 32'h77, 1'b0, "after_rst_wr");
    #2 check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
